// File: rtl/demux_1_8_reg.sv
// Registered 1-to-NUM_OUT byte demultiplexer. Each lane has a one-entry holding register
// with its own valid/ready handshake, so a stalled lane blocks only beats addressed to it.
module demux_1_8_reg #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 8,
    parameter int SEL_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [15:0]               acc_cnt,
    output logic [7:0]                drop_cnt,
    output logic                      sel_err
);

    localparam int SEL_N = 2 ** SEL_W;

    logic [SEL_N-1:0]   sel_ready;
    logic [NUM_OUT-1:0] sel_hit;
    logic [NUM_OUT-1:0] load;
    logic               accept;
    logic               sel_good;
    logic [15:0]        acc_cnt_reg;
    logic [7:0]         drop_cnt_reg;
    logic               sel_err_reg;

    // Unused select codes always accept so that bad beats are swallowed, never stalled.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_N; gi++) begin : g_sel_ready
            if (gi < NUM_OUT) begin : g_lane
                assign sel_ready[gi] = ~out_valid[gi] | out_ready[gi];
            end else begin : g_unused
                assign sel_ready[gi] = 1'b1;
            end
        end
    endgenerate

    assign in_ready = sel_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign sel_good = |sel_hit;

    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_lane
            logic              valid_reg;
            logic [DATA_W-1:0] data_reg;

            assign sel_hit[gi] = (in_sel == SEL_W'(gi));
            assign load[gi]    = accept & sel_hit[gi];

            // A load wins over a drain on the same edge, giving full-rate back-to-back beats.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (load[gi]) begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                end else if (out_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi]                  = valid_reg;
            assign out_data[gi*DATA_W +: DATA_W]  = data_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            sel_err_reg  <= 1'b0;
        end else if (accept) begin
            if (sel_good) begin
                acc_cnt_reg <= acc_cnt_reg + 16'd1;
            end else begin
                if (drop_cnt_reg != 8'hFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
                end
                sel_err_reg <= 1'b1;
            end
        end
    end

    assign acc_cnt  = acc_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
    assign sel_err  = sel_err_reg;

endmodule

// File: tb/tb_demux_1_8_reg.sv
// Bench for demux_1_8_reg: an 8-lane instance checked against a per-lane scoreboard, and a
// 6-lane instance exercising bad-select dropping.
module tb_demux_1_8_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_valid, out_ready;
    logic [63:0] out_data;
    logic [15:0] acc_cnt;
    logic [7:0]  drop_cnt;
    logic        sel_err;

    logic        in_valid6, in_ready6;
    logic [7:0]  in_data6;
    logic [2:0]  in_sel6;
    logic [5:0]  out_valid6, out_ready6;
    logic [47:0] out_data6;
    logic [15:0] acc_cnt6;
    logic [7:0]  drop_cnt6;
    logic        sel_err6;

    demux_1_8_reg #(.DATA_W(8), .NUM_OUT(8), .SEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .acc_cnt(acc_cnt), .drop_cnt(drop_cnt), .sel_err(sel_err)
    );

    demux_1_8_reg #(.DATA_W(8), .NUM_OUT(6), .SEL_W(3)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6), .in_sel(in_sel6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .acc_cnt(acc_cnt6), .drop_cnt(drop_cnt6), .sel_err(sel_err6)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb_q[0:7][$];
    int          rx_cnt[0:7];
    logic [7:0]  exp_byte;

    // One clock: at the falling edge record what the next rising edge will transfer
    // (pop drained lanes, push accepted beats), then step to just past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < 8; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    checks++;
                    if (sb_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL sb_lane%0d: got unexpected beat %h, expected no beat", i, out_data[i*8 +: 8]);
                    end else begin
                        exp_byte = sb_q[i].pop_front();
                        rx_cnt[i]++;
                        if (out_data[i*8 +: 8] !== exp_byte) begin
                            errors++;
                            $display("FAIL sb_lane%0d: got %h, expected %h", i, out_data[i*8 +: 8], exp_byte);
                        end
                    end
                end
            end
            if (in_valid && in_ready) sb_q[in_sel].push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 8; i++) begin
            sb_q[i].delete();
            rx_cnt[i] = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_data = 0; in_sel = 0; out_ready = 0;
        in_valid6 = 0; in_data6 = 0; in_sel6 = 0; out_ready6 = 0;
        #3;
        checks++;
        if (out_valid !== 8'h00 || out_data !== 64'h0 || acc_cnt !== 16'h0 || drop_cnt !== 8'h0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: got v=%h d=%h acc=%h drop=%h err=%b, expected all zero", out_valid, out_data, acc_cnt, drop_cnt, sel_err);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        out_ready = ~8'h24;
        in_valid = 1; in_sel = 3'd2; in_data = 8'h12;
        tick();
        in_sel = 3'd5; in_data = 8'h15;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 8'h24 || acc_cnt !== 16'd2) begin
            errors++;
            $display("FAIL reset_preload: got v=%h acc=%0d, expected v=24 acc=2", out_valid, acc_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 8'h00 || out_data !== 64'h0 || acc_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: got v=%h d=%h acc=%h, expected all zero before edge", out_valid, out_data, acc_cnt);
        end
        clear_sb();
        tick();
        rst_n = 1'b1;
        out_ready = 8'hFF;
        tick();
    endtask

    task automatic test_routing();
        out_ready = 8'hFF;
        in_valid = 1; in_sel = 3'd5; in_data = 8'h64;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 8'h20 || out_data[5*8 +: 8] !== 8'h64) begin
            errors++;
            $display("FAIL route_sel5: got v=%h lane5=%h, expected v=20 lane5=64", out_valid, out_data[5*8 +: 8]);
        end
        for (int s = 0; s < 8; s++) begin
            in_valid = 1; in_sel = 3'(s); in_data = 8'hA0 + 8'(s);
            tick();
            checks++;
            if (out_valid !== (8'h01 << s) || out_data[s*8 +: 8] !== 8'hA0 + 8'(s)) begin
                errors++;
                $display("FAIL route_lane%0d: got v=%h data=%h, expected v=%h data=%h", s, out_valid, out_data[s*8 +: 8], 8'h01 << s, 8'hA0 + 8'(s));
            end
        end
        in_valid = 0;
        tick();
        checks++;
        if (acc_cnt !== 16'd9 || out_valid !== 8'h00) begin
            errors++;
            $display("FAIL route_acc: got acc=%0d v=%h, expected acc=9 v=00", acc_cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 8'hF7;
        in_valid = 1; in_sel = 3'd3; in_data = 8'h11;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_ready: got %b, expected 1", in_ready);
        end
        tick();
        in_data = 8'h22;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_blocked: got in_ready=%b, expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid[3] !== 1'b1 || out_data[3*8 +: 8] !== 8'h11 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v3=%b lane3=%h rdy=%b, expected 1 11 0", out_valid[3], out_data[3*8 +: 8], in_ready);
        end
        in_valid = 0;
        tick();
        in_valid = 1; in_sel = 3'd4; in_data = 8'h44;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_lane: got in_ready=%b, expected 1", in_ready);
        end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 8'h18 || out_data[4*8 +: 8] !== 8'h44 || out_data[3*8 +: 8] !== 8'h11) begin
            errors++;
            $display("FAIL bp_lane4: got v=%h lane4=%h lane3=%h, expected v=18 44 11", out_valid, out_data[4*8 +: 8], out_data[3*8 +: 8]);
        end
        in_valid = 1; in_sel = 3'd3; in_data = 8'h22;
        out_ready = 8'hFF;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 8'h08 || out_data[3*8 +: 8] !== 8'h22) begin
            errors++;
            $display("FAIL bp_no_bubble: got v=%h lane3=%h, expected v=08 lane3=22", out_valid, out_data[3*8 +: 8]);
        end
        tick();
        checks++;
        if (out_valid !== 8'h00 || acc_cnt !== 16'd12) begin
            errors++;
            $display("FAIL bp_drain: got v=%h acc=%0d, expected v=00 acc=12", out_valid, acc_cnt);
        end
    endtask

    task automatic test_throughput();
        int stall = 0;
        clear_sb();
        out_ready = 8'hFF;
        for (int n = 0; n < 256; n++) begin
            in_valid = 1; in_sel = 3'(n % 8); in_data = 8'($urandom_range(0, 255));
            #1;
            if (in_ready !== 1'b1) stall++;
            tick();
        end
        in_valid = 0;
        tick(); tick();
        checks++;
        if (stall != 0) begin
            errors++;
            $display("FAIL tp_in_ready: got %0d stalled cycles, expected 0", stall);
        end
        checks++;
        if (acc_cnt !== 16'd268) begin
            errors++;
            $display("FAIL tp_acc: got %0d, expected 268 (12 earlier + 256)", acc_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_cnt[i] != 32 || sb_q[i].size() != 0) begin
                errors++;
                $display("FAIL tp_lane%0d_count: got %0d beats (%0d pending), expected 32 (0)", i, rx_cnt[i], sb_q[i].size());
            end
        end
        checks++;
        if (drop_cnt !== 8'h00 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL tp_no_drop: got drop=%h err=%b, expected 00 0", drop_cnt, sel_err);
        end
    endtask

    task automatic test_bad_sel();
        out_ready6 = 6'b111101;
        in_valid6 = 1; in_sel6 = 3'd1; in_data6 = 8'h31;
        tick();
        in_sel6 = 3'd6; in_data6 = 8'h55;
        #1;
        checks++;
        if (in_ready6 !== 1'b1) begin
            errors++;
            $display("FAIL bad_ready: got %b, expected 1", in_ready6);
        end
        tick();
        in_valid6 = 0;
        checks++;
        if (out_valid6 !== 6'b000010 || out_data6[1*8 +: 8] !== 8'h31 || drop_cnt6 !== 8'd1 || sel_err6 !== 1'b1 || acc_cnt6 !== 16'd1) begin
            errors++;
            $display("FAIL bad_first: got v=%b lane1=%h drop=%0d err=%b acc=%0d, expected 000010 31 1 1 1", out_valid6, out_data6[1*8 +: 8], drop_cnt6, sel_err6, acc_cnt6);
        end
        for (int n = 0; n < 300; n++) begin
            in_valid6 = 1; in_sel6 = (n % 2 == 0) ? 3'd7 : 3'd6; in_data6 = 8'(n);
            tick();
        end
        in_valid6 = 0;
        tick();
        checks++;
        if (drop_cnt6 !== 8'hFF || sel_err6 !== 1'b1 || acc_cnt6 !== 16'd1 || out_valid6 !== 6'b000010) begin
            errors++;
            $display("FAIL bad_saturate: got drop=%h err=%b acc=%0d v=%b, expected FF 1 1 000010", drop_cnt6, sel_err6, acc_cnt6, out_valid6);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #1;
        clear_sb();
        tick();
        rst_n = 1'b1;
        out_ready = 8'hFF;
        for (int n = 0; n < 65535; n++) begin
            in_valid = 1; in_sel = 3'(n % 8); in_data = 8'(n * 7);
            tick();
        end
        in_valid = 0;
        tick();
        checks++;
        if (acc_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_max: got %h, expected FFFF", acc_cnt);
        end
        in_valid = 1; in_sel = 3'd7; in_data = 8'h5A;
        tick();
        in_valid = 0;
        tick();
        checks++;
        if (acc_cnt !== 16'h0000 || sb_q[7].size() != 0) begin
            errors++;
            $display("FAIL wrap_zero: got acc=%h pending=%0d, expected 0000 0", acc_cnt, sb_q[7].size());
        end
    endtask

    initial begin
        clear_sb();
        test_reset();
        test_routing();
        test_backpressure();
        test_throughput();
        test_bad_sel();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
